// File: rtl/min_receive_fsm_pkg.sv
// min_receive_fsm_pkg: MIN framing constants, CRC-32 parameters and receiver state encoding
package min_receive_fsm_pkg;
    localparam logic [7:0]  MIN_SOF      = 8'hAA;
    localparam logic [7:0]  MIN_STUFF    = 8'h55;
    localparam logic [7:0]  MIN_EOF      = 8'h55;
    localparam logic [31:0] MIN_CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] MIN_CRC_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] MIN_CRC_XOR  = 32'hFFFFFFFF;
    typedef enum logic [2:0] {S_SOF, S_ID, S_LEN, S_PAY, S_CRC, S_EOF} state_e;
endpackage

// File: rtl/crc32_byte.sv
// crc32_byte: one-byte step of the reflected CRC-32, shared with the MIN transmitter
module crc32_byte
    import min_receive_fsm_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] crc_o
);
    // Eight LSB-first shift/xor steps folding the byte into the running CRC
    always_comb begin
        logic [31:0] c;
        c = crc_i ^ {24'd0, byte_i};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ MIN_CRC_POLY) : (c >> 1);
        crc_o = c;
    end
endmodule

// File: rtl/min_receive_fsm.sv
// min_receive_fsm: MIN byte-stream frame receiver; define MIN_RECEIVE_CRC_EN to check the CRC-32 trailer
module min_receive_fsm
    import min_receive_fsm_pkg::*;
#(
    parameter int N_DATA_BYTE = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic [7:0]               i_data,
    output logic                     o_valid,
    output logic                     o_err,
    output logic                     o_busy,
    output logic [7:0]               o_id,
    output logic [7:0]               o_len,
    output logic [8*N_DATA_BYTE-1:0] o_data
);
    localparam int         IW = (N_DATA_BYTE > 1) ? $clog2(N_DATA_BYTE) : 1;
    localparam logic [7:0] NB = 8'(N_DATA_BYTE);

    state_e     state_q;
    logic [1:0] aa_q;
    logic [7:0] k_q;
    logic [1:0] cb_q;
    logic [7:0] id_q;
    logic [7:0] len_q;
    logic [7:0] pay_q [N_DATA_BYTE];
    logic       crc_ok;

`ifdef MIN_RECEIVE_CRC_EN
    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] crc_rx_q;

    crc32_byte u_crc (
        .crc_i  (crc_q),
        .byte_i (i_data),
        .crc_o  (crc_d)
    );

    assign crc_ok = (crc_q ^ MIN_CRC_XOR) == crc_rx_q;
`else
    assign crc_ok = 1'b1;
`endif

    assign o_busy = (state_q != S_SOF);

    // Frame parser: a third AA in a row always (re)starts a header; otherwise unstuff, capture fields, judge at EOF
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_SOF;
            aa_q    <= '0;
            k_q     <= '0;
            cb_q    <= '0;
            id_q    <= '0;
            len_q   <= '0;
            for (int i = 0; i < N_DATA_BYTE; i++) pay_q[i] <= '0;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            o_id    <= '0;
            o_len   <= '0;
            o_data  <= '0;
`ifdef MIN_RECEIVE_CRC_EN
            crc_q    <= MIN_CRC_INIT;
            crc_rx_q <= '0;
`endif
        end else begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            if (i_en) begin
                if (aa_q == 2'd2 && i_data == MIN_SOF) begin
                    o_err   <= (state_q != S_SOF);
                    state_q <= S_ID;
                    aa_q    <= '0;
                    for (int i = 0; i < N_DATA_BYTE; i++) pay_q[i] <= '0;
`ifdef MIN_RECEIVE_CRC_EN
                    crc_q <= MIN_CRC_INIT;
`endif
                end else if (state_q == S_SOF) begin
                    aa_q <= (i_data == MIN_SOF) ? aa_q + 2'd1 : 2'd0;
                end else if (aa_q == 2'd2) begin
                    aa_q <= '0;
                    if (i_data != MIN_STUFF) begin
                        o_err   <= 1'b1;
                        state_q <= S_SOF;
                    end
                end else begin
                    aa_q <= (i_data == MIN_SOF) ? aa_q + 2'd1 : 2'd0;
                    case (state_q)
                        S_ID: begin
                            id_q    <= i_data;
                            state_q <= S_LEN;
`ifdef MIN_RECEIVE_CRC_EN
                            crc_q <= crc_d;
`endif
                        end
                        S_LEN: begin
                            if (i_data > NB) begin
                                o_err   <= 1'b1;
                                state_q <= S_SOF;
                                aa_q    <= '0;
                            end else begin
                                len_q   <= i_data;
                                k_q     <= '0;
                                cb_q    <= '0;
                                state_q <= (i_data == 8'd0) ? S_CRC : S_PAY;
`ifdef MIN_RECEIVE_CRC_EN
                                crc_q <= crc_d;
`endif
                            end
                        end
                        S_PAY: begin
                            pay_q[k_q[IW-1:0]] <= i_data;
                            k_q <= k_q + 8'd1;
                            if (k_q == len_q - 8'd1) state_q <= S_CRC;
`ifdef MIN_RECEIVE_CRC_EN
                            crc_q <= crc_d;
`endif
                        end
                        S_CRC: begin
                            cb_q <= cb_q + 2'd1;
                            if (cb_q == 2'd3) state_q <= S_EOF;
`ifdef MIN_RECEIVE_CRC_EN
                            crc_rx_q <= {crc_rx_q[23:0], i_data};
`endif
                        end
                        S_EOF: begin
                            state_q <= S_SOF;
                            aa_q    <= '0;
                            if (i_data == MIN_EOF && crc_ok) begin
                                o_valid <= 1'b1;
                                o_id    <= id_q;
                                o_len   <= len_q;
                                for (int i = 0; i < N_DATA_BYTE; i++) o_data[8*(N_DATA_BYTE-1-i) +: 8] <= pay_q[i];
                            end else begin
                                o_err <= 1'b1;
                            end
                        end
                        default: state_q <= S_SOF;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_min_receive_fsm.sv
// tb_min_receive_fsm: randomized frame-level scoreboard bench for min_receive_fsm (honours MIN_RECEIVE_CRC_EN)
module tb_min_receive_fsm;
    localparam int N = 8;
`ifdef MIN_RECEIVE_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif
    typedef logic [7:0] bq_t[$];
    typedef logic [7:0] pl_t[N];
    typedef struct {
        bit             v;
        logic [7:0]     id;
        logic [7:0]     len;
        logic [8*N-1:0] data;
        int             cyc;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_en;
    logic [7:0]     i_data;
    logic           o_valid;
    logic           o_err;
    logic           o_busy;
    logic [7:0]     o_id;
    logic [7:0]     o_len;
    logic [8*N-1:0] o_data;

    int             cyc = 0;
    int             checks = 0;
    int             errors = 0;
    ev_t            sb[$];
    ev_t            me;
    logic [7:0]     lg_id = '0;
    logic [7:0]     lg_len = '0;
    logic [8*N-1:0] lg_data = '0;

    min_receive_fsm #(.N_DATA_BYTE(N)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (i_en),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_err   (o_err),
        .o_busy  (o_busy),
        .o_id    (o_id),
        .o_len   (o_len),
        .o_data  (o_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, x, cyc);
        end
    endtask

    function automatic bq_t cat(bq_t a, bq_t b);
        foreach (b[i]) a.push_back(b[i]);
        return a;
    endfunction

    // Transmitter rule: after two AA in a row insert a 55 and restart the count
    function automatic bq_t stuff(bq_t r);
        bq_t o;
        int  c = 0;
        foreach (r[i]) begin
            o.push_back(r[i]);
            if (r[i] == 8'hAA) begin
                c++;
                if (c == 2) begin
                    o.push_back(8'h55);
                    c = 0;
                end
            end else c = 0;
        end
        return o;
    endfunction

    function automatic logic [31:0] crc32(bq_t r);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (r[i]) begin
            c ^= {24'd0, r[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t body(logic [7:0] id, int len, pl_t pl, bit flip);
        bq_t         r;
        logic [31:0] c;
        r.push_back(id);
        r.push_back(8'(len));
        for (int i = 0; i < len; i++) r.push_back(pl[i]);
        c = crc32(r) ^ {31'd0, flip};
        for (int i = 3; i >= 0; i--) r.push_back(c[8*i +: 8]);
        return stuff(r);
    endfunction

    function automatic ev_t ok_ev(logic [7:0] id, int len, pl_t pl);
        ev_t e;
        e.v = 1'b1;
        e.id = id;
        e.len = 8'(len);
        e.data = '0;
        for (int i = 0; i < len; i++) e.data[8*(N-1-i) +: 8] = pl[i];
        e.cyc = 0;
        lg_id = e.id;
        lg_len = e.len;
        lg_data = e.data;
        return e;
    endfunction

    function automatic ev_t err_ev();
        ev_t e;
        e.v = 1'b0;
        e.id = lg_id;
        e.len = lg_len;
        e.data = lg_data;
        e.cyc = 0;
        return e;
    endfunction

    function automatic logic [7:0] rb();
        case ($urandom_range(0, 3))
            0: return 8'hAA;
            1: return 8'h55;
            2: return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    // Drive the byte stream with random idle gaps; the expectation is queued when byte `term` is strobed
    task automatic send(input bq_t q, input int term, input ev_t e);
        int g;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            i_en = 1'b1;
            i_data = q[i];
            if (i == term) begin
                e.cyc = cyc;
                sb.push_back(e);
            end
            g = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 1);
            if (g > 0) begin
                @(negedge clk);
                i_en = 1'b0;
                repeat (g - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        i_en = 1'b0;
    endtask

    // Kinds: 0 good, 1 LEN too big, 2 bad EOF, 3 CRC flipped, 4 AA AA AA resync, 5 AA AA xx abort, 6 reset mid-frame
    task automatic run_frame(input int kind, input logic [7:0] id, input int len, input pl_t pl, input int len2);
        bq_t        hdr = '{8'hAA, 8'hAA, 8'hAA};
        bq_t        s;
        bq_t        pre;
        ev_t        e;
        logic [7:0] x;
        int         k;
        case (kind)
            0, 3: begin
                s = cat(hdr, body(id, len, pl, kind == 3));
                s.push_back(8'h55);
                e = (kind == 3 && CRC_EN) ? err_ev() : ok_ev(id, len, pl);
                send(s, s.size() - 1, e);
            end
            1: begin
                pre.push_back(id);
                pre.push_back(8'(len));
                s = cat(hdr, stuff(pre));
                send(s, s.size() - 1, err_ev());
            end
            2: begin
                s = cat(hdr, body(id, len, pl, 1'b0));
                do x = 8'($urandom); while (x == 8'h55);
                s.push_back(x);
                send(s, s.size() - 1, err_ev());
            end
            default: begin
                k = $urandom_range(0, len - 1);
                if (k > 0) pl[k-1] = 8'h00;
                pre.push_back(id);
                pre.push_back(8'(len));
                for (int i = 0; i < k; i++) pre.push_back(pl[i]);
                s = cat(hdr, stuff(pre));
                if (kind == 4) begin
                    s.push_back(8'hAA);
                    s.push_back(8'hAA);
                    s.push_back(8'hAA);
                    send(s, s.size() - 1, err_ev());
                    s = body(id + 8'd1, len2, pl, 1'b0);
                    s.push_back(8'h55);
                    e = ok_ev(id + 8'd1, len2, pl);
                    send(s, s.size() - 1, e);
                end else if (kind == 5) begin
                    s.push_back(8'hAA);
                    s.push_back(8'hAA);
                    do x = 8'($urandom); while (x == 8'hAA || x == 8'h55);
                    s.push_back(x);
                    send(s, s.size() - 1, err_ev());
                end else begin
                    send(s, -1, err_ev());
                    chk("busy_mid_frame", 64'(o_busy), 64'd1);
                    rst = 1'b1;
                    @(negedge clk);
                    chk("rst_valid", 64'(o_valid), 64'd0);
                    chk("rst_err", 64'(o_err), 64'd0);
                    chk("rst_busy", 64'(o_busy), 64'd0);
                    chk("rst_id_len", {48'd0, o_id, o_len}, 64'd0);
                    chk("rst_data", o_data, 64'd0);
                    rst = 1'b0;
                    lg_id = '0;
                    lg_len = '0;
                    lg_data = '0;
                    s = cat(hdr, body(id, len, pl, 1'b0));
                    s.push_back(8'h55);
                    e = ok_ev(id, len, pl);
                    send(s, s.size() - 1, e);
                end
            end
        endcase
    endtask

    // Monitor: every o_valid/o_err pulse must match the oldest queued expectation, one cycle after its strobe
    always @(negedge clk) begin
        if (!rst && (o_valid || o_err)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_pulse: got valid=%0b err=%0b expected no pulse (cycle %0d)", o_valid, o_err, cyc);
            end else begin
                me = sb.pop_front();
                chk("pulse_kind", {62'd0, o_valid, o_err}, me.v ? 64'd2 : 64'd1);
                chk("latency", 64'(cyc), 64'(me.cyc + 1));
                chk("out_id", 64'(o_id), 64'(me.id));
                chk("out_len", 64'(o_len), 64'(me.len));
                chk("out_data", o_data, me.data);
            end
        end
    end

    initial begin
        pl_t p1 = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        pl_t p2 = '{8'hAA, 8'hAA, 8'h55, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        pl_t pr;
        int  kind;
        int  len;
        rst = 1'b1;
        i_en = 1'b0;
        i_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_err", 64'(o_err), 64'd0);
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_id_len", {48'd0, o_id, o_len}, 64'd0);
        chk("reset_data", o_data, 64'd0);
        rst = 1'b0;
        run_frame(0, 8'h01, 2, p1, 0);
        run_frame(0, 8'h05, 8, p2, 0);
        run_frame(1, 8'h07, 9, p1, 0);
        run_frame(3, 8'h09, 3, p2, 0);
        run_frame(4, 8'h03, 4, p2, 0);
        run_frame(5, 8'h0B, 5, p2, 0);
        run_frame(2, 8'h0C, 1, p1, 0);
        run_frame(6, 8'h0D, 6, p2, 0);
        for (int f = 0; f < 150; f++) begin
            kind = $urandom_range(0, 6);
            foreach (pr[i]) pr[i] = rb();
            if (kind == 1) begin
                do len = $urandom_range(9, 255); while (len == 170);
            end else len = (kind >= 4) ? $urandom_range(1, N) : $urandom_range(0, N);
            run_frame(kind, rb(), len, pr, $urandom_range(0, N));
        end
        repeat (10) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
